// File: rtl/memoria_dados_core_if.sv
// Load/store bus between the ALU/write-back stage and the data memory.
// The master drives the access request; the slave returns the read word.
interface memoria_dados_core_if #(
    parameter int unsigned DATA_W = 32
);
    logic              memRead;
    logic              memWrite;
    logic [31:0]       endereco;
    logic [DATA_W-1:0] dadoEscrita;
    logic [DATA_W-1:0] dadoLido;

    modport master (
        output memRead,
        output memWrite,
        output endereco,
        output dadoEscrita,
        input  dadoLido
    );

    modport slave (
        input  memRead,
        input  memWrite,
        input  endereco,
        input  dadoEscrita,
        output dadoLido
    );
endinterface

// File: rtl/memoria_dados_core.sv
// Word-addressed data memory for the load/store stage.
// Synchronous writes, zero-latency gated reads, asynchronous whole-array clear.
// Addresses outside the array are neither written nor aliased: upper address
// bits must be zero or the access is ignored and reads return zero.
module memoria_dados_core #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    memoria_dados_core_if.slave  bus
);
    localparam int unsigned ENDER_W = 32;

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [ADDR_BITS-1:0] idx_c;
    logic                 addr_valid_c;
    logic                 wr_en_c;

    // Word index and range check; the second term covers non-power-of-two depths
    assign idx_c        = bus.endereco[ADDR_BITS-1:0];
    assign addr_valid_c = (bus.endereco[ENDER_W-1:ADDR_BITS] == '0) &&
                          (ENDER_W'(idx_c) < DEPTH);
    assign wr_en_c      = bus.memWrite && addr_valid_c;

    // Storage: reset clears every word at once; otherwise one word per write edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem_q[idx_c] <= bus.dadoEscrita;
        end
    end

    // Combinational read, forced to zero when disabled or out of range
    always_comb begin
        bus.dadoLido = '0;
        if (bus.memRead && addr_valid_c) begin
            bus.dadoLido = mem_q[idx_c];
        end
    end
endmodule

// File: tb/tb_memoria_dados_core.sv
// Scoreboard bench for memoria_dados_core: stimulus pushes expected read data
// computed from an array model; a negedge monitor pops and compares.
module tb_memoria_dados_core;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;

    logic clock;
    logic reset;

    memoria_dados_core_if #(.DATA_W(DATA_W)) bus ();

    memoria_dados_core #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_BITS(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model and scoreboard
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    string             name_q [$];
    int                errors = 0;
    int                checks = 0;

    // Monitor: read data is combinational, so compare mid-cycle on the falling edge
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [DATA_W-1:0] exp_v;
            string             nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            checks++;
            if (bus.dadoLido !== exp_v) begin
                errors++;
                $display("FAIL %s: dadoLido=%h expected=%h (endereco=%h memRead=%b t=%0t)",
                         nm, bus.dadoLido, exp_v, bus.endereco, bus.memRead, $time);
            end
        end
    end

    function automatic logic [DATA_W-1:0] model_read(input logic rd, input logic [31:0] addr);
        if (rd && addr < 32'(DEPTH)) return ref_mem[addr[7:0]];
        return '0;
    endfunction

    // One cycle: drive inputs just after the edge, queue the expected read,
    // then let the model take the write on the next rising edge.
    task automatic cycle(input logic rst, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [DATA_W-1:0] data,
                         input string nm);
        reset           = rst;
        bus.memRead     = rd;
        bus.memWrite    = wr;
        bus.endereco    = addr;
        bus.dadoEscrita = data;
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        end
        exp_q.push_back(model_read(rd, addr));
        name_q.push_back(nm);
        @(posedge clock);
        if (wr && !rst && addr < 32'(DEPTH)) ref_mem[addr[7:0]] = data;
        #1;
    endtask

    initial begin
        logic [31:0] addr;
        logic        rst;
        int          sel;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        reset           = 1'b1;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.endereco    = '0;
        bus.dadoEscrita = '0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        cycle(1'b1, 1'b1, 1'b0, 32'd0,   '0, "reset_rd0_during");
        cycle(1'b0, 1'b1, 1'b0, 32'd0,   '0, "reset_rd0");
        cycle(1'b0, 1'b1, 1'b0, 32'd5,   '0, "reset_rd5");
        cycle(1'b0, 1'b1, 1'b0, 32'd255, '0, "reset_rd255");

        // Basic write then read, and read gating
        cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0001, "wr0");
        cycle(1'b0, 1'b1, 1'b0, 32'd0, '0, "rd0_after_wr");
        cycle(1'b0, 1'b0, 1'b0, 32'd0, '0, "rd_gated_off");
        cycle(1'b0, 1'b1, 1'b0, 32'd0, '0, "rd_gated_on");

        // Boundary: last word, first out-of-range word, no aliasing
        cycle(1'b0, 1'b0, 1'b1, 32'd255, 32'hDEAD_BEEF, "wr255");
        cycle(1'b0, 1'b0, 1'b1, 32'd256, 32'hCAFE_F00D, "wr256");
        cycle(1'b0, 1'b1, 1'b0, 32'd255, '0, "rd255");
        cycle(1'b0, 1'b1, 1'b0, 32'd256, '0, "rd256_oob");
        cycle(1'b0, 1'b1, 1'b0, 32'd0,   '0, "rd0_no_alias");
        cycle(1'b0, 1'b1, 1'b1, 32'h8000_0007, 32'h1234_5678, "rdwr_high_bit");
        cycle(1'b0, 1'b1, 1'b0, 32'd7,   '0, "rd7_no_alias");

        // Same-address read and write
        cycle(1'b0, 1'b0, 1'b1, 32'd7, 32'hA5A5_A5A5, "wr7");
        cycle(1'b0, 1'b1, 1'b1, 32'd7, 32'h5A5A_5A5A, "rdwr7_before");
        cycle(1'b0, 1'b1, 1'b0, 32'd7, '0, "rd7_after");

        // Async reset mid-operation; write during reset is discarded
        cycle(1'b0, 1'b0, 1'b1, 32'd10, 32'h1111_1111, "wr10");
        cycle(1'b0, 1'b0, 1'b1, 32'd11, 32'h2222_2222, "wr11");
        cycle(1'b0, 1'b1, 1'b1, 32'd12, 32'h3333_3333, "wr12");
        cycle(1'b0, 1'b1, 1'b0, 32'd11, '0, "rd11_pre_reset");
        cycle(1'b1, 1'b1, 1'b1, 32'd11, 32'h4444_4444, "rd11_in_reset");
        cycle(1'b0, 1'b1, 1'b0, 32'd11, '0, "rd11_post_reset");
        cycle(1'b0, 1'b1, 1'b0, 32'd10, '0, "rd10_post_reset");
        cycle(1'b0, 1'b1, 1'b1, 32'd12, 32'h5555_5555, "wr12_first_after_reset");
        cycle(1'b0, 1'b1, 1'b0, 32'd12, '0, "rd12_first_after_reset");

        // Randomized traffic concentrated on a few addresses plus out-of-range ones
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      addr = $urandom;
            else if (sel == 1) addr = 32'd256 + 32'($urandom_range(0, 3));
            else if (sel < 4)  addr = 32'($urandom_range(0, 255));
            else               addr = 32'($urandom_range(0, 15));
            rst = ($urandom_range(0, 59) == 0);
            cycle(rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  addr, $urandom, "random");
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected reads left unchecked, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
